// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software-register slaves: register map,
// control-bit positions and status packing.
package opb_sw_reg_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_ID     = 2'd3
    } reg_off_e;

    localparam logic [31:0] REG_ID_VALUE = 32'h53324350;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_FREEZE_BIT = 1;
    localparam int CTRL_CLR_BIT    = 31;

    localparam int OVF_W = 8;
    localparam logic [OVF_W-1:0] OVF_MAX  = 8'hFF;
    localparam logic [OVF_W-1:0] OVF_ZERO = 8'h00;
    localparam logic [OVF_W-1:0] OVF_ONE  = 8'h01;

    // STATUS layout: new-data flag in the MSB, overrun count in the low byte.
    function automatic logic [31:0] status_word(input logic new_flag,
                                                input logic [OVF_W-1:0] ovf_cnt);
        return {new_flag, 23'h000000, ovf_cnt};
    endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// Generic OPB slave front end: address decode, registered one-shot transfer
// acknowledge and read-data gating so the data bus is zero outside the ack.
module opb_slave_ack #(
    parameter logic [31:0] C_BASEADDR   = 32'h01004100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010041FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    select,
    input  logic                    rnw,
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic [C_OPB_DWIDTH-1:0] rdata,
    output logic                    hit,
    output logic [1:0]              word_off,
    output logic                    xfer_ack,
    output logic [0:C_OPB_DWIDTH-1] dbus
);

    logic                    in_window_s;
    logic                    ack_q, ack_d;
    logic [0:C_OPB_DWIDTH-1] dbus_q, dbus_d;

    // A hit arriving while the ack is still high is the tail of the same
    // transfer, so it is suppressed to keep the ack a single-cycle pulse.
    always_comb begin
        in_window_s = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
        hit         = select && in_window_s && !ack_q;
        ack_d       = hit;
        if (hit && rnw) begin
            dbus_d = rdata;
        end else begin
            dbus_d = {C_OPB_DWIDTH{1'b0}};
        end
    end

    assign word_off = abus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];

    // Ack and read data registered together at the hit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            dbus_q <= {C_OPB_DWIDTH{1'b0}};
        end else begin
            ack_q  <= ack_d;
            dbus_q <= dbus_d;
        end
    end

    assign xfer_ack = ack_q;
    assign dbus     = dbus_q;

endmodule

// File: rtl/opb_register_simulink2ppc_cap.sv
// OPB slave exposing a word captured from Simulink user logic, with new-data
// and overrun status, capture control and a constant ID register.
module opb_register_simulink2ppc_cap
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01004100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010041FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6",
    parameter logic [31:0] INIT_VALUE   = 32'h00000000
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid
);

    logic             hit_s;
    logic [1:0]       word_off_s;
    reg_off_e         off_s;
    logic [31:0]      wdata_s;
    logic [31:0]      rdata_s;
    logic             capture_s;
    logic             data_rd_s;
    logic             ctrl_wr_s;
    logic             ctrl_clr_s;

    logic [31:0]      cap_q, cap_d;
    logic             new_flag_q, new_flag_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             ctrl_en_q, ctrl_en_d;
    logic             ctrl_freeze_q, ctrl_freeze_d;

    opb_slave_ack #(
        .C_BASEADDR  (C_BASEADDR),
        .C_HIGHADDR  (C_HIGHADDR),
        .C_OPB_AWIDTH(C_OPB_AWIDTH),
        .C_OPB_DWIDTH(C_OPB_DWIDTH)
    ) u_ack (
        .clk     (OPB_Clk),
        .rst_n   (OPB_Rst_n),
        .select  (OPB_select),
        .rnw     (OPB_RNW),
        .abus    (OPB_ABus),
        .rdata   (rdata_s),
        .hit     (hit_s),
        .word_off(word_off_s),
        .xfer_ack(Sl_xferAck),
        .dbus    (Sl_DBus)
    );

    assign off_s   = reg_off_e'(word_off_s);
    assign wdata_s = OPB_DBus;

    // Event strobes; the clear bit lives in the byte selected by BE[0].
    always_comb begin
        capture_s  = user_valid && ctrl_en_q && !ctrl_freeze_q;
        data_rd_s  = hit_s && OPB_RNW && (off_s == REG_DATA);
        ctrl_wr_s  = hit_s && !OPB_RNW && (off_s == REG_CTRL);
        ctrl_clr_s = ctrl_wr_s && OPB_BE[0] && wdata_s[CTRL_CLR_BIT];
    end

    // Read-data mux, sampled by the ack block at the hit edge.
    always_comb begin
        rdata_s = 32'h00000000;
        case (off_s)
            REG_DATA:   rdata_s = cap_q;
            REG_STATUS: rdata_s = status_word(new_flag_q, ovf_q);
            REG_CTRL:   rdata_s = {30'h00000000, ctrl_freeze_q, ctrl_en_q};
            REG_ID:     rdata_s = REG_ID_VALUE;
            default:    rdata_s = 32'h00000000;
        endcase
    end

    // A capture always wins the new flag; a same-edge read-clear cancels
    // the overrun it would otherwise have counted.
    always_comb begin
        cap_d         = cap_q;
        new_flag_d    = new_flag_q;
        ovf_d         = ovf_q;
        ctrl_en_d     = ctrl_en_q;
        ctrl_freeze_d = ctrl_freeze_q;

        if (capture_s) begin
            cap_d      = user_data_in;
            new_flag_d = 1'b1;
        end else if (data_rd_s || ctrl_clr_s) begin
            new_flag_d = 1'b0;
        end else begin
            new_flag_d = new_flag_q;
        end

        if (ctrl_clr_s) begin
            ovf_d = OVF_ZERO;
        end else if (capture_s && new_flag_q && !data_rd_s && (ovf_q != OVF_MAX)) begin
            ovf_d = ovf_q + OVF_ONE;
        end else begin
            ovf_d = ovf_q;
        end

        if (ctrl_wr_s && OPB_BE[3]) begin
            ctrl_en_d     = wdata_s[CTRL_EN_BIT];
            ctrl_freeze_d = wdata_s[CTRL_FREEZE_BIT];
        end else begin
            ctrl_en_d     = ctrl_en_q;
            ctrl_freeze_d = ctrl_freeze_q;
        end
    end

    // Capture, status and control state.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cap_q         <= INIT_VALUE;
            new_flag_q    <= 1'b0;
            ovf_q         <= OVF_ZERO;
            ctrl_en_q     <= 1'b1;
            ctrl_freeze_q <= 1'b0;
        end else begin
            cap_q         <= cap_d;
            new_flag_q    <= new_flag_d;
            ovf_q         <= ovf_d;
            ctrl_en_q     <= ctrl_en_d;
            ctrl_freeze_q <= ctrl_freeze_d;
        end
    end

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_s;
    assign unused_s = ^{OPB_seqAddr, OPB_BE[1:2], wdata_s[30:2]};

endmodule

// File: doc/opb_register_simulink2ppc_cap.md
Name: opb_register_simulink2ppc_cap

Overview:
- Reverse-direction companion to the PPC-to-Simulink software register: the OPB slave through which the PPC reads values produced by Simulink user logic.
- User logic presents a 32-bit word with a capture strobe. The block latches it, tracks new-data and overrun status, and answers OPB reads.
- It sits on the same OPB bus segment as the other software registers, in the OPB_Clk domain.
- User logic must already be synchronous to OPB_Clk; CDC is out of scope.

Parameters:
- C_BASEADDR, 32'h01004100: first byte address of the decode window.
- C_HIGHADDR, 32'h010041FF: last byte address of the decode window.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width.
- C_FAMILY, "virtex6": target family; informational only.
- INIT_VALUE, 32'h00000000: reset value of the capture register.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  address; bit 0 is the MSB.
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck = 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_in  in  [31:0]  value from Simulink.
- user_valid  in  1  capture strobe, one cycle per word.

Behaviour:
- Reset: OPB_Rst_n low asynchronously forces:
  - capture register = INIT_VALUE
  - new_flag = 0, ovf_cnt = 0
  - ctrl_en = 1, ctrl_freeze = 0
  - Sl_xferAck = 0, Sl_DBus = 0
  - Deassertion takes effect on the next OPB_Clk edge.
- Decode: hit = OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The word offset is OPB_ABus[28:29].
- Register map (byte offset):
  - 0x0 DATA (RO): captured word.
  - 0x4 STATUS (RO): bit31 new_flag, bits[7:0] ovf_cnt, all other bits 0.
  - 0x8 CTRL (RW): bit0 ctrl_en, bit1 ctrl_freeze; a write with bit31 = 1 clears ovf_cnt and new_flag and is self-clearing, so bit31 reads back 0.
  - 0xC ID (RO): constant 32'h53324350.
- Handshake:
  - Sl_xferAck is registered: it asserts in the cycle after hit is seen, for exactly one cycle.
  - A hit while Sl_xferAck = 1 is ignored, so back-to-back selects give an ack on every other cycle.
  - Read data is sampled at the hit edge and driven on Sl_DBus only during the ack cycle.
  - If select drops before the ack, the ack still fires once; masters must tolerate this.
- Writes: only CTRL is writable, and only the bytes whose BE bit is set. Writes to other offsets are acked and discarded.
- Capture:
  - When user_valid && ctrl_en && !ctrl_freeze, the capture register loads user_data_in on that edge and new_flag is set.
  - If new_flag was already 1, ovf_cnt increments, saturating at 255.
  - user_valid with capture disabled is dropped and does not count as an overrun.
- Read side-effect: a DATA read clears new_flag at the hit edge. This is the read-clear.
- Same-edge capture and DATA read: the read returns the old value, new_flag ends at 1, and ovf_cnt is unchanged.
- Same-edge capture and CTRL clear: the capture still loads data, new_flag ends at 1, and ovf_cnt ends at 0.
- Reset mid-transfer: the ack is aborted and no ack is issued after reset release.

Decomposition:
- Shared package opb_sw_reg_pkg:
  - register offset constants and the ID constant
  - CTRL bit indices
  - OVF_W = 8
- One natural sub-module, opb_slave_ack: decode, registered one-shot ack, and the read-data mux gate. It is reusable by other software registers.

Test Plan:
- Reset release, then read ID at 0x0100410C -> ack after 1 cycle, DBus = 0x53324350; DBus = 0 in all non-ack cycles.
- user_valid with 0xDEADBEEF; read STATUS -> 0x80000000; read DATA -> 0xDEADBEEF; read STATUS -> 0x00000000.
- Three strobes with no read -> STATUS = 0x80000002. Then 300 further strobes -> ovf_cnt saturates at 0xFF. Write CTRL = 0x80000001 -> STATUS = 0x00000000.
- Write CTRL = 0x00000003 (freeze set), then strobe 0x12345678 -> DATA unchanged, new_flag = 0.
- Capture 0x11111111 on the same edge as a DATA read hit -> returned 0xDEADBEEF-era old value, new_flag = 1; the next DATA read returns 0x11111111.
- Select held 4 cycles at an out-of-window address 0x01004200 -> no ack. Select held at 0x01004100 -> acks in cycles 2 and 4 only. Assert OPB_Rst_n low in the hit cycle -> no ack follows.
